riscv_mem_responder: RTL and testbench
======================================

RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the word count of the backing RAM (4096 bytes).
REQ-002 Parameter GPIO_W, default 8, SHALL set the width of the GPIO output register (1..8).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load/fetch.
REQ-008 req_addr  input  32  byte address, word-aligned.
REQ-009 req_wdata  input  32  store data, lane-aligned.
REQ-010 req_be  input  4  byte-lane enables; bit i selects bits 8i+7:8i.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data.
REQ-014 rsp_err  output  1  request was rejected.
REQ-015 gpio  output  GPIO_W  memory-mapped GPIO register.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; IDLE->ACCESS on acceptance; ACCESS->RESP unconditionally; RESP->IDLE on an edge with rsp_ready=1.
REQ-018 Only one request SHALL be outstanding; the fixed latency SHALL be rsp_valid=1 from the second edge after acceptance.
REQ-019 rsp_valid, rsp_rdata and rsp_err SHALL stay stable in RESP until rsp_ready=1; rsp_valid SHALL be 0 outside RESP.
REQ-020 Legal req_be values SHALL be 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
REQ-021 Error SHALL be flagged if req_addr[1:0]!=0, req_be is illegal, or the address is outside the RAM and GPIO regions.
REQ-022 RAM region SHALL be addresses 0 .. DEPTH_WORDS*4-1; word index = req_addr[11:2].
REQ-023 GPIO region SHALL be the single word at GPIO_ADDR = 0x0000_1000.
REQ-024 A legal RAM store SHALL write only the enabled byte lanes on the accept edge.
REQ-025 A legal GPIO store with req_be[0]=1 SHALL load gpio from req_wdata[GPIO_W-1:0] on the accept edge; otherwise gpio SHALL be unchanged.
REQ-026 A legal RAM load SHALL return the full addressed word regardless of req_be; lane extraction and sign extension belong to the initiator.
REQ-027 A GPIO load SHALL return gpio zero-extended to 32 bits.
REQ-028 A store or errored request SHALL return rsp_rdata=0; an errored store SHALL modify no state.
REQ-029 A load from a word stored earlier SHALL return the updated data, because the store completes before the next request can be accepted.
REQ-030 If rsp_ready=1 on the edge rsp_valid rises, the FSM SHALL leave RESP on the following edge; the next acceptance SHALL occur no earlier than the cycle after that (peak rate one request per 3 cycles).

Reset
REQ-031 While rst_n=0 the block SHALL hold: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio=0.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Reset asserted mid-transaction SHALL drop the pending response; a store already committed on its accept edge SHALL remain.

Structure
REQ-034 Shared package riscv_pkg SHALL hold XLEN=32, GPIO_ADDR, the legal byte-enable encodings and the responder state enum.
REQ-035 RAM SHALL be a sub-module riscv_ram_1rw: synchronous-read, byte-write-enabled, single port, DEPTH_WORDS x 32.

Verification
REQ-036 Store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 edges after each accept.
REQ-037 Store 0x0000AB00 to 0x10 with be=0010 after REQ-036 -> load 0x10 returns 0xDEADABEF.
REQ-038 Store 0x5A to 0x1000 with be=0001 -> gpio=0x5A on the accept edge; load 0x1000 -> rsp_rdata=0x0000005A.
REQ-039 Load 0x2000; load 0x12; store with be=0101 -> each gives rsp_err=1 and rsp_rdata=0, and RAM and gpio are unchanged.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> outputs are stable and req_ready=0; after rsp_ready=1, the next request is accepted 2 edges later.
REQ-041 Pull rst_n low during ACCESS of a load -> rsp_valid stays 0 and the FSM returns to IDLE with all outputs at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V memory responder: data width, GPIO
// location, legal byte-enable encodings and the responder state machine.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // Single-word GPIO register location
    localparam logic [XLEN-1:0] GPIO_ADDR = 32'h0000_1000;

    // Legal byte-lane enable patterns: single bytes, aligned halves, full word
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } rsp_state_e;

    // Source of the load data presented in RESP
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_GPIO = 2'd2
    } rd_src_e;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF0, BE_HALF1, BE_WORD: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_ram_1rw.sv
// Single-port RAM, synchronous read, per-byte write enables. Contents are
// deliberately not reset.
module riscv_ram_1rw
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic            clk,
    input  logic            en,
    input  logic [3:0]      we_be,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we_be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory responder for a simple RISC-V initiator: one outstanding request,
// fixed IDLE -> ACCESS -> RESP sequence, backing RAM plus one GPIO word.
module riscv_mem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [GPIO_W-1:0] gpio
);

    localparam int unsigned     AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(DEPTH_WORDS * 4);

    rsp_state_e      state;
    rd_src_e         rd_src;
    logic            pend_err;

    logic            accept;
    logic            addr_aligned;
    logic            ram_hit;
    logic            gpio_hit;
    logic            req_err;
    logic            ram_en;
    logic [3:0]      ram_we_be;
    logic [XLEN-1:0] ram_rdata;

    // Request decode: region hit, legality and RAM port control
    always_comb begin
        accept       = req_valid && req_ready;
        addr_aligned = (req_addr[1:0] == 2'b00);
        ram_hit      = (req_addr < RAM_LIMIT);
        // RAM decode wins should a large DEPTH_WORDS ever cover GPIO_ADDR
        gpio_hit     = (req_addr == GPIO_ADDR) && !ram_hit;
        req_err      = !addr_aligned || !be_legal(req_be) || !(ram_hit || gpio_hit);
        ram_en       = accept && !req_err && ram_hit;
        ram_we_be    = (ram_en && req_we) ? req_be : '0;
    end

    riscv_ram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we_be (ram_we_be),
        .addr  (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // Responder FSM with registered handshake, response and GPIO outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            gpio      <= '0;
            rd_src    <= SRC_ZERO;
            pend_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        state     <= ACCESS;
                        req_ready <= 1'b0;
                        pend_err  <= req_err;
                        if (req_err || req_we) begin
                            rd_src <= SRC_ZERO;
                        end else if (ram_hit) begin
                            rd_src <= SRC_RAM;
                        end else begin
                            rd_src <= SRC_GPIO;
                        end
                        if (!req_err && gpio_hit && req_we && req_be[0]) begin
                            gpio <= req_wdata[GPIO_W-1:0];
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= pend_err;
                    case (rd_src)
                        SRC_RAM:  rsp_rdata <= ram_rdata;
                        SRC_GPIO: rsp_rdata <= XLEN'(gpio);
                        default:  rsp_rdata <= '0;
                    endcase
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboard bench for riscv_mem_responder: directed requests push their
// expected response; an independent monitor checks each response.
module tb_riscv_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  gpio;

    int          n_cmp;
    int          n_bad;
    int          cyc;

    logic [31:0] exp_d_q [$];
    logic        exp_e_q [$];
    int          acc_q   [$];

    riscv_mem_responder #(
        .DEPTH_WORDS (1024),
        .GPIO_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .gpio      (gpio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Present one request, wait (bounded) for acceptance, queue its expectation
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                         output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: addr %h never accepted", a);
            req_valid = 1'b0;
        end else begin
            acc = cyc;
            exp_d_q.push_back(exp_d);
            exp_e_q.push_back(exp_e);
            acc_q.push_back(cyc);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drop_last;
        if (exp_d_q.size() > 0) begin
            void'(exp_d_q.pop_back());
            void'(exp_e_q.pop_back());
            void'(acc_q.pop_back());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_gpio"},      32'(gpio), 32'd0);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_d_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: compare each new response, then its stability while held
    logic        in_resp;
    logic [31:0] held_d;
    logic        held_e;
    always @(negedge clk) begin
        if (!rst_n || !rsp_valid) begin
            in_resp = 1'b0;
        end else if (!in_resp) begin
            in_resp = 1'b1;
            held_d  = rsp_rdata;
            held_e  = rsp_err;
            if (exp_d_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_rsp: got rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_d_q.pop_front());
                chk("rsp_err", 32'(rsp_err), 32'(exp_e_q.pop_front()));
                chk("latency", 32'(cyc - acc_q.pop_front()), 32'd2);
            end
        end else begin
            chk("hold_rdata", rsp_rdata, held_d);
            chk("hold_err", 32'(rsp_err), 32'(held_e));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
    end

    initial begin
        int a0, a1, r, n;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Full-word store/load and peak request rate
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, a0);
        issue(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, a1);
        chk("accept_spacing", 32'(a1 - a0), 32'd3);

        // Single-lane store merges into the word; load ignores be
        issue(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, a0);
        issue(1'b0, 32'h10, 32'h0, 4'b0001, 32'hDEADABEF, 1'b0, a0);

        // Last RAM word
        issue(1'b1, 32'hFFC, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, a0);
        issue(1'b0, 32'hFFC, 32'h0, 4'b1111, 32'h0BADF00D, 1'b0, a0);

        // GPIO store visible right after the accept edge, then read back
        issue(1'b1, 32'h1000, 32'h0000005A, 4'b0001, 32'h0, 1'b0, a0);
        chk("gpio_after_store", 32'(gpio), 32'h5A);
        issue(1'b0, 32'h1000, 32'h0, 4'b1111, 32'h0000005A, 1'b0, a0);
        issue(1'b1, 32'h1000, 32'h0000FF00, 4'b0010, 32'h0, 1'b0, a0);
        chk("gpio_be0_clear", 32'(gpio), 32'h5A);

        // Rejected requests: out of range, misaligned, illegal be
        issue(1'b0, 32'h2000, 32'h0, 4'b1111, 32'h0, 1'b1, a0);
        issue(1'b0, 32'h12, 32'h0, 4'b1111, 32'h0, 1'b1, a0);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b1, a0);
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b1, a0);
        issue(1'b1, 32'h1004, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, a0);
        chk("gpio_after_errors", 32'(gpio), 32'h5A);
        issue(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADABEF, 1'b0, a0);
        drain();

        // Backpressure: response held for 5 cycles, then next accept 2 edges on
        rsp_ready = 1'b0;
        issue(1'b0, 32'hFFC, 32'h0, 4'b1111, 32'h0BADF00D, 1'b0, a0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        r = cyc;
        issue(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADABEF, 1'b0, a1);
        chk("bp_next_accept", 32'(a1 - r), 32'd1);
        drain();

        // Reset during ACCESS of a load drops the response
        issue(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADABEF, 1'b0, a0);
        rst_n = 1'b0;
        drop_last();
        @(negedge clk);
        check_reset_outputs("midrst1");
        @(negedge clk);
        chk("midrst2_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        issue(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADABEF, 1'b0, a0);

        // Reset during ACCESS of a store keeps the committed write
        issue(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, a0);
        rst_n = 1'b0;
        drop_last();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4'b1111, 32'h11223344, 1'b0, a0);

        drain();
        chk("queue_drained", 32'(exp_d_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
